sprite_blitter: RTL
===================

SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- DISP_WIDTH, 240, display columns.
- DISP_HEIGHT, 320, display rows.
- COORD_WIDTH, 11, signed coordinate width.
- PIXEL_WIDTH, 16, colour word width.
- ROM_ADDR_WIDTH, 16, ROM address width.
- ROM_LATENCY, 2, cycles from address to valid data (>=1).
- TRANSPARENT, 16'h0001, colour key that is never written.
REQ-002 Ports, one per line: name, direction, width, meaning:
- clock, in, 1, single clock.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, level request to draw.
- abort, in, 1, cancel current draw.
- xOrigin, in, COORD_WIDTH signed, destination column of sprite pixel (0,0).
- yOrigin, in, COORD_WIDTH signed, destination row of sprite pixel (0,0).
- romBase, in, ROM_ADDR_WIDTH, sprite header address.
- mirrorX, in, 1, horizontal flip.
- mirrorY, in, 1, vertical flip.
- scaleLog2, in, 2, scale factor 2^scaleLog2 (0..2; 3 treated as 2).
- romAddr, out, ROM_ADDR_WIDTH, ROM read address.
- romData, in, PIXEL_WIDTH, ROM read data.
- xAddr, out, COORD_WIDTH, pixel column.
- yAddr, out, COORD_WIDTH, pixel row.
- pixelData, out, PIXEL_WIDTH, pixel colour.
- pixelWrite, out, 1, write request.
- pixelReady, in, 1, sink accept.
- busy, out, 1, draw in progress.
- done, out, 1, one-cycle completion pulse.
- pixelCount, out, 20, pixels written by last draw.
REQ-003 The block SHALL use one clock, clock, and reset reset_n, which is asynchronous and active-low.

Function
REQ-004 Sprite format: romBase+0 holds width W (romData[7:0]), romBase+1 holds height H (romData[7:0]), romBase+2 onward holds W*H pixels, row-major. ROM addresses wrap modulo 2^ROM_ADDR_WIDTH.
REQ-005 Each ROM read: romAddr is driven in cycle t, and romData is sampled in cycle t+ROM_LATENCY. The block SHALL hold romAddr stable over that interval.
REQ-006 States: IDLE, HDR_W, HDR_H, FETCH, EMIT, WAIT, ADVANCE.
- IDLE: busy=0. On start=1, latch origin, romBase, mirrorX, mirrorY and scaleLog2, clear pixelCount, then go to HDR_W.
REQ-007 HDR_W -> HDR_H -> FETCH. If W==0 or H==0, go to IDLE with a done pulse and no writes.
REQ-008 Destination loop: dy 0..(H<<s)-1 outer, dx 0..(W<<s)-1 inner, where s=scaleLog2.
- srcCol = dx>>s, reflected to W-1-srcCol when mirrorX.
- srcRow = dy>>s, reflected to H-1-srcRow when mirrorY.
- Address = romBase+2+srcRow*W+srcCol, formed from a row-base accumulator (no multiplier required).
REQ-009 FETCH: read the pixel, then go to EMIT.
- EMIT: if colour==TRANSPARENT or the target is off-screen, go to ADVANCE with no write.
- Target is (xOrigin+dx, yOrigin+dy). It is off-screen when x<0, x>=DISP_WIDTH, y<0 or y>=DISP_HEIGHT.
- Otherwise drive xAddr/yAddr/pixelData, assert pixelWrite, and go to WAIT.
REQ-010 WAIT: a write is accepted in the cycle where pixelWrite&&pixelReady.
- pixelWrite drops the next cycle; pixelCount increments; state goes to ADVANCE.
- xAddr, yAddr and pixelData SHALL stay stable while pixelWrite=1.
REQ-011 ADVANCE: step dx. At the row end, reset dx to 0 and step dy. After the final pixel, go to IDLE and pulse done for exactly one cycle.
REQ-012 busy SHALL be 1 in every state except IDLE.
- start while busy is ignored.
- start still high at completion begins a new draw with freshly latched inputs.
REQ-013 abort=1 in any non-IDLE state: next cycle go to IDLE with pixelWrite=0 and no done pulse. pixelCount holds the writes accepted so far.
REQ-014 Coordinate arithmetic SHALL be signed at COORD_WIDTH+1 bits internally so that clipping comparisons never wrap.

Reset
REQ-015 On reset_n=0, all of the following SHALL take effect asynchronously:
- state=IDLE.
- busy=0, done=0, pixelWrite=0.
- romAddr=0, xAddr=0, yAddr=0, pixelData=0.
- pixelCount=0.
REQ-016 Reset asserted mid-draw SHALL abandon the draw immediately, with no further pixel or done output after release.

Verification
REQ-017 The bench SHALL cover the following directed scenarios:
- 3x2 sprite at (10,20), no mirror, s=0, pixelReady always 1 -> 6 writes in order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); done pulse; pixelCount=6.
- Same sprite, mirrorX=1, s=1 -> 24 writes. The first write is at (10,20) with pixel index 2, duplicated at x 10..11 and rows 20..21.
- 4x4 sprite at (-2,318) -> only the 2x2 on-screen pixels (x 0..1, y 318..319) are written; pixelCount=4.
- Sprite with all pixels 16'h0001 -> 0 writes, done pulse, pixelCount=0. Also W=0 -> done with no ROM pixel reads.
- pixelReady held 0 for 5 cycles during a write -> pixelWrite and address/data stay stable until acceptance, and exactly one count per accepted write.
- abort after the 3rd accepted write, then reset_n pulsed mid-draw -> IDLE with no done pulse. pixelCount=3 after abort, 0 after reset.

Source files
------------

// File: rtl/sprite_blitter_if.sv
// Bus bundle for the sprite blitter: draw request, ROM read port and pixel sink.
// master is the blitter side, slave is the requester/ROM/framebuffer side.
interface sprite_blitter_if #(
    parameter int COORD_WIDTH    = 11,
    parameter int PIXEL_WIDTH    = 16,
    parameter int ROM_ADDR_WIDTH = 16
);
    logic                          start;
    logic                          abort;
    logic signed [COORD_WIDTH-1:0] xOrigin;
    logic signed [COORD_WIDTH-1:0] yOrigin;
    logic [ROM_ADDR_WIDTH-1:0]     romBase;
    logic                          mirrorX;
    logic                          mirrorY;
    logic [1:0]                    scaleLog2;
    logic [ROM_ADDR_WIDTH-1:0]     romAddr;
    logic [PIXEL_WIDTH-1:0]        romData;
    logic [COORD_WIDTH-1:0]        xAddr;
    logic [COORD_WIDTH-1:0]        yAddr;
    logic [PIXEL_WIDTH-1:0]        pixelData;
    logic                          pixelWrite;
    logic                          pixelReady;
    logic                          busy;
    logic                          done;
    logic [19:0]                   pixelCount;

    modport master (
        input  start, abort, xOrigin, yOrigin, romBase, mirrorX, mirrorY, scaleLog2,
        input  romData, pixelReady,
        output romAddr, xAddr, yAddr, pixelData, pixelWrite, busy, done, pixelCount
    );

    modport slave (
        output start, abort, xOrigin, yOrigin, romBase, mirrorX, mirrorY, scaleLog2,
        output romData, pixelReady,
        input  romAddr, xAddr, yAddr, pixelData, pixelWrite, busy, done, pixelCount
    );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter: reads a W x H sprite from ROM and writes it to a clipped display,
// with optional X/Y mirroring, power-of-two scaling and a transparent colour key.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start, inputs latched on start
// S_HDR_W   | reading sprite width from romBase+0
// S_HDR_H   | reading sprite height from romBase+1, set up walk
// S_FETCH   | reading the source pixel for (dx,dy)
// S_EMIT    | transparency / clip decision, launch write
// S_WAIT    | holding write until pixelReady
// S_ADVANCE | step dx/dy and source pointers, issue next read
module sprite_blitter #(
    parameter int                   DISP_WIDTH     = 240,
    parameter int                   DISP_HEIGHT    = 320,
    parameter int                   COORD_WIDTH    = 11,
    parameter int                   PIXEL_WIDTH    = 16,
    parameter int                   ROM_ADDR_WIDTH = 16,
    parameter int                   ROM_LATENCY    = 2,
    parameter logic [PIXEL_WIDTH-1:0] TRANSPARENT  = 16'h0001
) (
    input logic              clock,
    input logic              reset_n,
    sprite_blitter_if.master bus
);
    localparam int CW    = COORD_WIDTH;
    localparam int RW    = ROM_ADDR_WIDTH;
    localparam int PW    = PIXEL_WIDTH;
    localparam int CNT_W = $clog2(ROM_LATENCY + 1);
    localparam logic signed [CW:0] DISP_W_S = (CW+1)'(DISP_WIDTH);
    localparam logic signed [CW:0] DISP_H_S = (CW+1)'(DISP_HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_W, S_HDR_H, S_FETCH, S_EMIT, S_WAIT, S_ADVANCE
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  rd_cnt;
    logic [RW-1:0]     base_q, row_base, rom_addr;
    logic [CW-1:0]     x_org, y_org, dx, dy, x_addr, y_addr;
    logic              mir_x, mir_y, pix_wr, done_q;
    logic [1:0]        scl, sx_sub, sy_sub;
    logic [7:0]        w_q, h_q, src_col;
    logic [PW-1:0]     pix_q, pix_out;
    logic [19:0]       pix_cnt;

    logic              rd_done, hdr_zero, emit_ok, accept, row_end, last_row;
    logic [7:0]        h_rd, init_col, nxt_col;
    logic [15:0]       mir_off;
    logic [RW-1:0]     init_row, nxt_row_base;
    logic [1:0]        sub_max;
    logic [CW-1:0]     dx_last, dy_last;
    logic signed [CW:0] x_tgt, y_tgt;

    always_comb begin
        rd_done  = (rd_cnt == '0);
        h_rd     = bus.romData[7:0];
        hdr_zero = (w_q == 8'd0) || (h_rd == 8'd0);
        case (scl)
            2'd0:    sub_max = 2'd0;
            2'd1:    sub_max = 2'd1;
            default: sub_max = 2'd3;
        endcase
        dx_last  = (CW'(w_q) << scl) - CW'(1);
        dy_last  = (CW'(h_q) << scl) - CW'(1);
        row_end  = (dx == dx_last);
        last_row = (dy == dy_last);
        // one extra bit keeps negative origins and far-right targets from wrapping
        x_tgt    = $signed({x_org[CW-1], x_org}) + $signed({1'b0, dx});
        y_tgt    = $signed({y_org[CW-1], y_org}) + $signed({1'b0, dy});
        emit_ok  = (pix_q != TRANSPARENT) && !x_tgt[CW] && (x_tgt < DISP_W_S)
                   && !y_tgt[CW] && (y_tgt < DISP_H_S);
        accept   = pix_wr && bus.pixelReady;

        mir_off  = 16'(h_rd - 8'd1) * 16'(w_q);
        init_col = mir_x ? (w_q - 8'd1) : 8'd0;
        init_row = base_q + RW'(2) + (mir_y ? RW'(mir_off) : '0);

        nxt_col      = src_col;
        nxt_row_base = row_base;
        if (row_end) begin
            nxt_col = init_col;
            if (sy_sub == sub_max)
                nxt_row_base = mir_y ? (row_base - RW'(w_q)) : (row_base + RW'(w_q));
        end else if (sx_sub == sub_max) begin
            nxt_col = mir_x ? (src_col - 8'd1) : (src_col + 8'd1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (bus.start) state_nxt = S_HDR_W;
            S_HDR_W:   if (rd_done) state_nxt = S_HDR_H;
            S_HDR_H:   if (rd_done) state_nxt = hdr_zero ? S_IDLE : S_FETCH;
            S_FETCH:   if (rd_done) state_nxt = S_EMIT;
            S_EMIT:    state_nxt = emit_ok ? S_WAIT : S_ADVANCE;
            S_WAIT:    if (accept) state_nxt = S_ADVANCE;
            S_ADVANCE: state_nxt = (row_end && last_row) ? S_IDLE : S_FETCH;
            default:   state_nxt = S_IDLE;
        endcase
        if (bus.abort && state != S_IDLE)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt   <= '0;
            base_q   <= '0;
            row_base <= '0;
            rom_addr <= '0;
            x_org    <= '0;
            y_org    <= '0;
            dx       <= '0;
            dy       <= '0;
            x_addr   <= '0;
            y_addr   <= '0;
            mir_x    <= 1'b0;
            mir_y    <= 1'b0;
            pix_wr   <= 1'b0;
            done_q   <= 1'b0;
            scl      <= '0;
            sx_sub   <= '0;
            sy_sub   <= '0;
            w_q      <= '0;
            h_q      <= '0;
            src_col  <= '0;
            pix_q    <= '0;
            pix_out  <= '0;
            pix_cnt  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    x_org    <= bus.xOrigin;
                    y_org    <= bus.yOrigin;
                    base_q   <= bus.romBase;
                    mir_x    <= bus.mirrorX;
                    mir_y    <= bus.mirrorY;
                    scl      <= (bus.scaleLog2 == 2'd3) ? 2'd2 : bus.scaleLog2;
                    pix_cnt  <= '0;
                    rom_addr <= bus.romBase;
                    rd_cnt   <= CNT_W'(ROM_LATENCY);
                end
                S_HDR_W: if (rd_done) begin
                    w_q      <= bus.romData[7:0];
                    rom_addr <= base_q + RW'(1);
                    rd_cnt   <= CNT_W'(ROM_LATENCY);
                end else rd_cnt <= rd_cnt - CNT_W'(1);
                S_HDR_H: if (rd_done) begin
                    h_q <= h_rd;
                    if (hdr_zero) begin
                        done_q <= 1'b1;
                    end else begin
                        dx       <= '0;
                        dy       <= '0;
                        sx_sub   <= '0;
                        sy_sub   <= '0;
                        src_col  <= init_col;
                        row_base <= init_row;
                        rom_addr <= init_row + RW'(init_col);
                        rd_cnt   <= CNT_W'(ROM_LATENCY);
                    end
                end else rd_cnt <= rd_cnt - CNT_W'(1);
                S_FETCH: if (rd_done) pix_q <= bus.romData;
                         else         rd_cnt <= rd_cnt - CNT_W'(1);
                S_EMIT: if (emit_ok) begin
                    x_addr  <= x_tgt[CW-1:0];
                    y_addr  <= y_tgt[CW-1:0];
                    pix_out <= pix_q;
                    pix_wr  <= 1'b1;
                end
                S_WAIT: if (accept) begin
                    pix_wr  <= 1'b0;
                    pix_cnt <= pix_cnt + 20'd1;
                end
                S_ADVANCE: begin
                    if (row_end) begin
                        dx     <= '0;
                        sx_sub <= '0;
                        if (last_row) begin
                            done_q <= 1'b1;
                        end else begin
                            dy     <= dy + CW'(1);
                            sy_sub <= (sy_sub == sub_max) ? 2'd0 : sy_sub + 2'd1;
                        end
                    end else begin
                        dx     <= dx + CW'(1);
                        sx_sub <= (sx_sub == sub_max) ? 2'd0 : sx_sub + 2'd1;
                    end
                    src_col  <= nxt_col;
                    row_base <= nxt_row_base;
                    rom_addr <= nxt_row_base + RW'(nxt_col);
                    rd_cnt   <= CNT_W'(ROM_LATENCY);
                end
                default: ;
            endcase
            // an accepted write in the abort cycle still counts (handled above)
            if (bus.abort && state != S_IDLE) begin
                pix_wr <= 1'b0;
                done_q <= 1'b0;
            end
        end
    end

    assign bus.romAddr    = rom_addr;
    assign bus.xAddr      = x_addr;
    assign bus.yAddr      = y_addr;
    assign bus.pixelData  = pix_out;
    assign bus.pixelWrite = pix_wr;
    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = done_q;
    assign bus.pixelCount = pix_cnt;
endmodule
